// File: rtl/fifo_stream_pkg.sv
// Shared types and width helpers for the FIFO stream consumers.
package fifo_stream_pkg;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } packer_state_t;

  // Lane count must be able to hold PACK_N itself, hence the +1.
  function automatic int lane_cnt_width(input int pack_n);
    return $clog2(pack_n + 1);
  endfunction

  function automatic int timer_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/flush_timer.sv
// Idle counter: raises expired on the TIMEOUT-th consecutive enabled cycle.
module flush_timer
  import fifo_stream_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  assign expired = count_en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops DATA_W-bit FIFO entries and packs PACK_N of them little-endian into a
// wide valid/ready word; partial words leave on idle timeout or flush.
module fifo_word_packer
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PACK_N  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       fifo_rd_en,
  input  logic [DATA_W-1:0]          fifo_dout,
  input  logic                       fifo_empty,
  input  logic                       flush_req,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W*PACK_N-1:0]   m_data,
  output logic [PACK_N-1:0]          m_keep,
  output logic                       m_partial,
  output logic                       busy
);

  localparam int LCW = lane_cnt_width(PACK_N);
  localparam logic [LCW:0]   PACK_N_W  = (LCW + 1)'(PACK_N);
  localparam logic [LCW-1:0] LAST_LANE = LCW'(PACK_N - 1);

  packer_state_t state_q, state_d;
  logic [LCW-1:0] lane_cnt_q, lane_cnt_d;
  logic rd_pend_q, rd_pend_d;
  logic flush_pend_q, flush_pend_d;
  logic [DATA_W*PACK_N-1:0] data_q, data_d;
  logic [PACK_N-1:0] keep_q, keep_d;
  logic partial_q, partial_d;

  logic [LCW:0] occupancy;
  logic capture, handshake, timer_en, timer_clear, timer_expired;
  logic flush_go, flush_drop, go_emit;

  // Lanes already filled plus the one still in flight from the FIFO.
  assign occupancy  = {1'b0, lane_cnt_q} + {{LCW{1'b0}}, rd_pend_q};
  assign fifo_rd_en = rst && (state_q == FILL) && !fifo_empty &&
                      (occupancy < PACK_N_W) && !flush_pend_q;

  // rd_pend is only ever set from FILL, and EMIT is never entered with one pending.
  assign capture    = rd_pend_q;
  assign handshake  = (state_q == EMIT) && m_ready;
  assign timer_en   = (state_q == FILL) && (lane_cnt_q != '0) && !rd_pend_q && fifo_empty;
  assign timer_clear = capture || !fifo_empty || handshake;
  assign flush_go   = (state_q == FILL) && flush_pend_q && (lane_cnt_q != '0) && !rd_pend_q;
  assign flush_drop = (state_q == FILL) && flush_pend_q && (lane_cnt_q == '0) && !rd_pend_q;

  assign m_valid   = (state_q == EMIT);
  assign m_data    = data_q;
  assign m_keep    = keep_q;
  assign m_partial = partial_q;
  assign busy      = (state_q != FILL) || (lane_cnt_q != '0) || rd_pend_q;

  flush_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_flush_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .count_en (timer_en),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    rd_pend_d    = fifo_rd_en;
    data_d       = data_q;
    keep_d       = keep_q;
    partial_d    = partial_q;
    flush_pend_d = flush_pend_q;

    case (state_q)
      FILL: begin
        if (capture) begin
          for (int i = 0; i < PACK_N; i++) begin
            if (lane_cnt_q == LCW'(i)) begin
              data_d[i*DATA_W +: DATA_W] = fifo_dout;
              keep_d[i] = 1'b1;
            end
          end
          lane_cnt_d = lane_cnt_q + 1'b1;
          if (lane_cnt_q == LAST_LANE) begin
            state_d   = EMIT;
            partial_d = 1'b0;
          end
        end else if (timer_expired || flush_go) begin
          state_d   = EMIT;
          partial_d = ({1'b0, lane_cnt_q} < PACK_N_W);
        end
      end
      EMIT: begin
        if (m_ready) begin
          state_d    = FILL;
          lane_cnt_d = '0;
          data_d     = '0;
          keep_d     = '0;
          partial_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase

    go_emit = (state_q == FILL) && (state_d == EMIT);
    if (flush_drop) begin
      flush_pend_d = 1'b0;
    end
    if (flush_req && (state_q == FILL)) begin
      flush_pend_d = 1'b1;
    end
    if (go_emit) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FILL;
      lane_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      partial_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      rd_pend_q    <= rd_pend_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      partial_q    <= partial_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural one-cycle-latency FIFO.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty;
  logic        flush_req = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_partial;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  logic empty_mask = 1'b0;

  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  logic        got_part[$];
  logic [31:0] exp_q[$];
  int viol_empty = 0;
  int viol_emit = 0;

  fifo_word_packer #(
    .DATA_W  (8),
    .PACK_N  (4),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .flush_req  (flush_req),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_partial  (m_partial),
    .busy       (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // FIFO model: read data appears the cycle after a qualified pop
  assign fifo_empty = empty_mask || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  // Monitor: inputs settle #1 after posedge, so negedge shows what the next edge sees
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_keep.push_back(m_keep);
      got_part.push_back(m_partial);
    end
    if (fifo_rd_en && fifo_empty) viol_empty++;
    if (fifo_rd_en && m_valid) viol_emit++;
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (got_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(2);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=00000000", m_data); end
    checks++; if (m_keep !== 4'h0) begin failures++; $display("FAIL reset_m_keep got=%b exp=0000", m_keep); end
    checks++; if (m_partial !== 1'b0) begin failures++; $display("FAIL reset_m_partial got=%b exp=0", m_partial); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    step(2);
  endtask

  task automatic test_full_word();
    int base, pbase;
    bit ok;
    base = got_data.size();
    pbase = pop_cnt;
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_beats(base + 1, 40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL full_beat_timeout got=none exp=1 beat");
    end else begin
      checks++; if (got_data[base] !== 32'h44332211) begin failures++; $display("FAIL full_data got=%h exp=44332211", got_data[base]); end
      checks++; if (got_keep[base] !== 4'b1111) begin failures++; $display("FAIL full_keep got=%b exp=1111", got_keep[base]); end
      checks++; if (got_part[base] !== 1'b0) begin failures++; $display("FAIL full_partial got=%b exp=0", got_part[base]); end
    end
    step(5);
    checks++; if (pop_cnt - pbase !== 4) begin failures++; $display("FAIL full_pop_count got=%0d exp=4", pop_cnt - pbase); end
    checks++; if (got_data.size() !== base + 1) begin failures++; $display("FAIL full_beat_count got=%0d exp=%0d", got_data.size(), base + 1); end
  endtask

  task automatic test_timeout_partial();
    int base, first;
    bit ok;
    base = got_data.size();
    first = -1;
    m_ready = 1'b1;
    step(1);
    push(8'hAA); push(8'hBB);
    // Two pops/captures finish three edges in, then sixteen idle cycles run.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_valid) begin
        first = k;
        break;
      end
    end
    checks++; if (first !== 19) begin failures++; $display("FAIL timeout_latency got=%0d exp=19", first); end
    wait_beats(base + 1, 10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL timeout_beat_timeout got=none exp=1 beat");
    end else begin
      checks++; if (got_data[base] !== 32'h0000BBAA) begin failures++; $display("FAIL timeout_data got=%h exp=0000bbaa", got_data[base]); end
      checks++; if (got_keep[base] !== 4'b0011) begin failures++; $display("FAIL timeout_keep got=%b exp=0011", got_keep[base]); end
      checks++; if (got_part[base] !== 1'b1) begin failures++; $display("FAIL timeout_partial got=%b exp=1", got_part[base]); end
    end
    step(2);
  endtask

  task automatic test_backpressure();
    int base, emit_base;
    bit ok;
    base = got_data.size();
    emit_base = viol_emit;
    m_ready = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    for (int b = 1; b <= 8; b++) push(8'(b));
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin failures++; $display("FAIL stall_valid_timeout got=0 exp=1"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'h04030201 || m_keep !== 4'hF || fifo_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got valid=%b data=%h keep=%b rd_en=%b exp valid=1 data=04030201 keep=1111 rd_en=0",
                 c, m_valid, m_data, m_keep, fifo_rd_en);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_beats(base + 2, 40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL stall_beats_timeout got=%0d exp=2", got_data.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_data[base + i] !== exp_q[i]) begin
          failures++; $display("FAIL stall_order beat=%0d got=%h exp=%h", i, got_data[base + i], exp_q[i]);
        end
      end
    end
    step(3);
    checks++; if (got_data.size() !== base + 2) begin failures++; $display("FAIL stall_beat_count got=%0d exp=%0d", got_data.size(), base + 2); end
    checks++; if (viol_emit !== emit_base) begin failures++; $display("FAIL rd_en_in_emit got=%0d exp=%0d", viol_emit, emit_base); end
  endtask

  task automatic test_flush();
    int base, busy_hits, pbase;
    bit ok;
    base = got_data.size();
    m_ready = 1'b1;
    push(8'h10); push(8'h20); push(8'h30);
    step(6);
    flush_req = 1'b1;
    step(1);
    flush_req = 1'b0;
    wait_beats(base + 1, 10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL flush_beat_timeout got=none exp=1 beat");
    end else begin
      checks++; if (got_data[base] !== 32'h00302010) begin failures++; $display("FAIL flush_data got=%h exp=00302010", got_data[base]); end
      checks++; if (got_keep[base] !== 4'b0111) begin failures++; $display("FAIL flush_keep got=%b exp=0111", got_keep[base]); end
      checks++; if (got_part[base] !== 1'b1) begin failures++; $display("FAIL flush_partial got=%b exp=1", got_part[base]); end
    end
    step(5);
    base = got_data.size();
    pbase = pop_cnt;
    busy_hits = 0;
    flush_req = 1'b1;
    step(1);
    flush_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hits++;
    end
    checks++; if (busy_hits !== 0) begin failures++; $display("FAIL empty_flush_busy got=%0d exp=0 busy cycles", busy_hits); end
    checks++; if (got_data.size() !== base) begin failures++; $display("FAIL empty_flush_beat got=%0d exp=0 beats", got_data.size() - base); end
    checks++; if (pop_cnt !== pbase) begin failures++; $display("FAIL empty_flush_pops got=%0d exp=0", pop_cnt - pbase); end
    step(1);
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    base = got_data.size();
    m_ready = 1'b1;
    push(8'h51); push(8'h52); push(8'h53);
    step(3);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL midrst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL midrst_m_data got=%h exp=00000000", m_data); end
    checks++; if (m_keep !== 4'h0) begin failures++; $display("FAIL midrst_m_keep got=%b exp=0000", m_keep); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    step(25);
    checks++; if (got_data.size() !== base) begin failures++; $display("FAIL midrst_no_beat got=%0d exp=0 beats", got_data.size() - base); end
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    wait_beats(base + 1, 40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL midrst_beat_timeout got=none exp=1 beat");
    end else begin
      checks++; if (got_data[base] !== 32'hA4A3A2A1) begin failures++; $display("FAIL midrst_data got=%h exp=a4a3a2a1", got_data[base]); end
      checks++; if (got_keep[base] !== 4'b1111) begin failures++; $display("FAIL midrst_keep got=%b exp=1111", got_keep[base]); end
    end
    step(3);
  endtask

  task automatic test_toggle_empty();
    int base, vbase;
    bit ok;
    base = got_data.size();
    vbase = viol_empty;
    m_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h03020100);
    exp_q.push_back(32'h07060504);
    exp_q.push_back(32'h0B0A0908);
    for (int b = 0; b < 12; b++) push(8'(b));
    ok = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      empty_mask = ~empty_mask;
      if (got_data.size() >= base + 3) begin
        ok = 1'b1;
        break;
      end
    end
    empty_mask = 1'b0;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL toggle_beats_timeout got=%0d exp=3", got_data.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_data[base + i] !== exp_q[i]) begin
          failures++; $display("FAIL toggle_data beat=%0d got=%h exp=%h", i, got_data[base + i], exp_q[i]);
        end
      end
    end
    checks++; if (viol_empty !== vbase) begin failures++; $display("FAIL rd_en_while_empty got=%0d exp=%0d", viol_empty, vbase); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_timeout_partial();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_toggle_empty();
    checks++; if (viol_empty !== 0) begin failures++; $display("FAIL global_rd_en_while_empty got=%0d exp=0", viol_empty); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the parameterized synchronous FIFO. It pops DATA_W-bit entries and packs PACK_N of them, little-endian, into one wide word. The word goes out on a valid/ready stream. A partial word is emitted after TIMEOUT idle cycles or on an explicit flush, and is marked with a byte-keep mask.

Parameters:
DATA_W, 8, width of one FIFO entry
PACK_N, 4, entries per output word (≥2)
TIMEOUT, 16, idle cycles before a partial word is flushed (≥2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
fifo_rd_en  output  1  pop request to FIFO
fifo_dout  input  DATA_W  FIFO read data, valid one cycle after a qualified pop
fifo_empty  input  1  FIFO empty flag
flush_req  input  1  single-cycle request to emit any partial word
m_valid  output  1  output word valid
m_ready  input  1  downstream accept
m_data  output  DATA_W*PACK_N  packed word, entry 0 in bits [DATA_W-1:0]
m_keep  output  PACK_N  per-lane valid mask
m_partial  output  1  word carries fewer than PACK_N entries
busy  output  1  state≠FILL or lane_cnt≠0 or read in flight

Behaviour:
- Reset (rst=0 at a clk edge) takes effect on the next cycle:
  - m_valid=0, m_data=0, m_keep=0, m_partial=0, fifo_rd_en=0, busy=0.
  - State returns to FILL, lane_cnt=0, timer=0, rd_pend=0.
- FIFO read contract:
  - A pop is qualified when fifo_rd_en=1 and fifo_empty=0.
  - fifo_dout is captured on the following cycle.
  - rd_pend is a register holding "qualified pop last cycle".
- fifo_rd_en is combinational: state==FILL && !fifo_empty && (lane_cnt + rd_pend) < PACK_N && !flush_pending.
  - fifo_rd_en is never asserted while fifo_empty=1.
  - fifo_rd_en is never asserted in EMIT.
- Capture: when rd_pend=1, lane[lane_cnt] ← fifo_dout, m_keep[lane_cnt] ← 1, lane_cnt ← lane_cnt+1.
- States: FILL, EMIT.
- FILL → EMIT when any of:
  - (a) a capture makes lane_cnt reach PACK_N (m_partial=0);
  - (b) timer expiry;
  - (c) flush_pending with lane_cnt>0 and rd_pend=0.
  - For (b) and (c), m_partial=1 if lane_cnt<PACK_N.
  - m_valid rises in the cycle after the transition edge.
- Timer:
  - Counts while in FILL with lane_cnt>0, rd_pend=0 and fifo_empty=1.
  - Cleared on any capture, or when fifo_empty=0.
  - Expires when the count reaches TIMEOUT-1, i.e. TIMEOUT idle cycles.
- flush_req:
  - Sets flush_pending, which blocks new pops.
  - The flush completes when the in-flight read (if any) has been captured.
  - If lane_cnt=0 and rd_pend=0, the flush is dropped and no beat is produced.
  - flush_pending clears on entering EMIT or on being dropped.
  - flush_req during EMIT is ignored.
- EMIT:
  - m_valid=1; m_data, m_keep and m_partial are held stable until m_valid && m_ready.
  - On the handshake, in the same edge: clear lane_cnt, m_keep, m_data and timer, then go to FILL.
  - m_valid may not drop without a handshake.
- Unused lanes of a partial word are 0.
- lane_cnt is $clog2(PACK_N+1) bits wide. The sum lane_cnt+rd_pend is computed one bit wider.
- Reset mid-operation discards the partial word and any read in flight.
  - No beat is emitted.
  - fifo_dout arriving the cycle after reset is ignored.
- Throughput: one word per PACK_N+2 cycles when the FIFO stays non-empty and m_ready=1.

Decomposition:
- Package fifo_stream_pkg:
  - typedef enum {FILL, EMIT} packer_state_t;
  - localparam functions for lane-count width and timer width ($clog2(TIMEOUT)).
- Sub-module flush_timer:
  - Parameter TIMEOUT.
  - Inputs clk, rst, clear, count_en; output expired.
  - Holds the idle counter.
- Everything else stays in fifo_word_packer.

Test Plan:
1. FIFO model preloaded with 0x11,0x22,0x33,0x44, m_ready=1 -> one beat: m_data=0x44332211, m_keep=4'b1111, m_partial=0; exactly 4 pops.
2. Only 0xAA,0xBB available, FIFO then empty -> after 16 idle cycles one beat: m_data=0x0000BBAA, m_keep=4'b0011, m_partial=1.
3. 8 bytes 0x01..0x08 with m_ready=0 for 10 cycles -> m_valid held and m_data=0x04030201 stable; fifo_rd_en=0 throughout EMIT; after release, second beat 0x08070605; no loss or reorder.
4. flush_req pulsed with 3 bytes (0x10,0x20,0x30) captured -> next beat m_data=0x00302010, m_keep=4'b0111, m_partial=1. flush_req pulsed with lane_cnt=0 -> no beat; busy stays 0.
5. rst=0 with 2 bytes captured and one pop in flight -> next cycle all outputs 0 and no beat. The following 4 bytes 0xA1..0xA4 pack as 0xA4A3A2A1 from lane 0.
6. fifo_empty toggling every cycle while supplying 0x00..0x0B -> fifo_rd_en never high while fifo_empty=1; beats 0x03020100, 0x07060504, 0x0B0A0908.
